// File: rtl/init_rd_responder.sv
// Round-robin read responder: grants one client, fetches LEN words from a 1-cycle SRAM
// and streams them through a 2-deep fall-through buffer, then pulses completion.
module init_rd_responder #(
  parameter int NUM_CLIENTS  = 4,
  parameter int ID_WTH       = 8,
  parameter int ADDR_WTH     = 32,
  parameter int LEN_WTH      = 16,
  parameter int DATA_WTH     = 512,
  parameter int MEM_ADDR_WTH = 20
) (
  input  logic                            clk_intf,
  input  logic                            rst,
  input  logic [NUM_CLIENTS-1:0]          init_rd_req,
  input  logic [NUM_CLIENTS*ID_WTH-1:0]   init_rd_req_id,
  input  logic [NUM_CLIENTS*ADDR_WTH-1:0] init_rd_addr,
  input  logic [NUM_CLIENTS*LEN_WTH-1:0]  init_rd_len,
  output logic [NUM_CLIENTS-1:0]          init_rd_req_ack,
  output logic [NUM_CLIENTS*DATA_WTH-1:0] init_rd_data,
  output logic [NUM_CLIENTS-1:0]          init_rd_data_vld,
  input  logic [NUM_CLIENTS-1:0]          init_rd_data_rdy,
  output logic [NUM_CLIENTS-1:0]          init_rd_cmpl,
  output logic                            mem_rd_en,
  output logic [MEM_ADDR_WTH-1:0]         mem_rd_addr,
  input  logic [DATA_WTH-1:0]             mem_rd_data,
  output logic                            busy
);

  localparam int GW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, STREAM, CMPL} state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       rr_ptr, gnt, sel, idx;
  logic                found;
  logic [ADDR_WTH-1:0] cur_addr;
  logic [LEN_WTH-1:0]  cur_len, issued, sent;
  logic                inflight;
  logic [DATA_WTH-1:0] fifo_mem [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          count;
  logic                vld, pop, push, issue, last_beat;
  logic [DATA_WTH-1:0] head;
  logic                unused_bits;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = GW'((int'(rr_ptr) + i) % NUM_CLIENTS);
      if (!found && init_rd_req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Head falls through from the SRAM when the buffer is empty so the first beat
  // appears in the same cycle its read data returns.
  assign vld       = (state == STREAM) && ((count != 2'd0) || inflight);
  assign head      = (count != 2'd0) ? fifo_mem[rd_ptr] : mem_rd_data;
  assign pop       = vld && init_rd_data_rdy[gnt];
  assign push      = inflight && !(pop && (count == 2'd0));
  assign issue     = (state == STREAM) && (({1'b0, count} + {2'b0, inflight}) < 3'd2)
                     && (issued != cur_len);
  assign last_beat = pop && (sent == cur_len - LEN_WTH'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   state_nxt = (cur_len == '0) ? CMPL : STREAM;
      STREAM:  if (last_beat) state_nxt = CMPL;
      CMPL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_intf or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      cur_addr <= '0;
      cur_len  <= '0;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (state == IDLE && found) begin
        gnt      <= sel;
        cur_addr <= init_rd_addr[sel*ADDR_WTH +: ADDR_WTH];
        cur_len  <= init_rd_len[sel*LEN_WTH +: LEN_WTH];
        issued   <= '0;
        sent     <= '0;
        rr_ptr   <= (sel == GW'(NUM_CLIENTS - 1)) ? '0 : sel + GW'(1);
      end
      if (issue) issued <= issued + LEN_WTH'(1);
      if (pop) sent <= sent + LEN_WTH'(1);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop && count != 2'd0) rd_ptr <= ~rd_ptr;
      if (push && !pop) count <= count + 2'd1;
      else if (pop && !push && count != 2'd0) count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk_intf) begin
    if (push) fifo_mem[wr_ptr] <= mem_rd_data;
  end

  always_comb begin
    init_rd_req_ack  = '0;
    init_rd_data_vld = '0;
    init_rd_cmpl     = '0;
    init_rd_data     = '0;
    if (state == GRANT) init_rd_req_ack[gnt] = 1'b1;
    if (state == CMPL) init_rd_cmpl[gnt] = 1'b1;
    if (vld) begin
      init_rd_data_vld[gnt] = 1'b1;
      init_rd_data[gnt*DATA_WTH +: DATA_WTH] = head;
    end
  end

  assign mem_rd_en   = issue;
  assign mem_rd_addr = cur_addr[MEM_ADDR_WTH-1:0] + MEM_ADDR_WTH'(issued);
  assign busy        = (state != IDLE);

  // Ids and high address bits carry no meaning for the SRAM side.
  assign unused_bits = ^{init_rd_req_id, cur_addr[ADDR_WTH-1:MEM_ADDR_WTH]};

endmodule

// File: tb/tb_init_rd_responder.sv
// Directed table-driven bench for init_rd_responder with a behavioural 1-cycle SRAM.
module tb_init_rd_responder;

  localparam int NC = 4, IDW = 8, AW = 32, LW = 16, DW = 32, MAW = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     req;
  logic [NC*IDW-1:0] req_id;
  logic [NC*AW-1:0]  addr_bus;
  logic [NC*LW-1:0]  len_bus;
  logic [NC-1:0]     ack;
  logic [NC*DW-1:0]  data_bus;
  logic [NC-1:0]     vld;
  logic [NC-1:0]     rdy;
  logic [NC-1:0]     cmpl;
  logic              mem_rd_en;
  logic [MAW-1:0]    mem_rd_addr;
  logic [DW-1:0]     mem_rd_data;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  init_rd_responder #(
    .NUM_CLIENTS(NC), .ID_WTH(IDW), .ADDR_WTH(AW), .LEN_WTH(LW),
    .DATA_WTH(DW), .MEM_ADDR_WTH(MAW)
  ) dut (
    .clk_intf(clk), .rst(rst),
    .init_rd_req(req), .init_rd_req_id(req_id), .init_rd_addr(addr_bus), .init_rd_len(len_bus),
    .init_rd_req_ack(ack), .init_rd_data(data_bus), .init_rd_data_vld(vld),
    .init_rd_data_rdy(rdy), .init_rd_cmpl(cmpl),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  function automatic logic [DW-1:0] memf(input logic [MAW-1:0] a);
    return 32'hA500_0000 ^ {12'h0, a};
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= memf(mem_rd_addr);

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] bus_of(input int c, input logic [DW-1:0] d);
    logic [127:0] b;
    b = {96'b0, d};
    return b << (c * DW);
  endfunction

  task automatic set_req(input int c, input logic [AW-1:0] a, input int l);
    addr_bus[c*AW +: AW] = a;
    len_bus[c*LW +: LW]  = LW'(l);
    req_id[c*IDW +: IDW] = IDW'(8'h30 + c);
    req[c] = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_cmpl"}, cmpl, 0);
    chk({tag, "_mem_en"}, mem_rd_en, 0);
    chk({tag, "_mem_addr"}, mem_rd_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_data"}, data_bus, 0);
  endtask

  typedef struct {
    int          client;
    logic [31:0] addr;
    int          len;
    int          rdy_mode;      // 0: rdy held high, 1: 1-0-0-1 then random
    int          exp_ack;
    int          exp_cmpl;      // -1 when rdy is random
    logic [19:0] exp_first_mem;
  } vec_t;

  vec_t tbl[6];

  task automatic run_txn(input vec_t v);
    int c, cyc, beats, issued, cmpl_cyc, k;
    logic prev_vld, prev_rdy, r;
    logic [DW-1:0] prev_data;
    logic [NC-1:0] onehot;
    logic [MAW-1:0] ea;
    c = v.client; cyc = 0; beats = 0; issued = 0; cmpl_cyc = -1; k = 0;
    prev_vld = 1'b0; prev_rdy = 1'b0; prev_data = '0;
    onehot = NC'(1) << c;
    set_req(c, v.addr, v.len);
    rdy = (v.rdy_mode == 0) ? onehot : '0;
    while (cmpl_cyc < 0 && cyc < 200) begin
      tick();
      cyc++;
      if (ack != 0) begin
        chk("ack_onehot", ack, onehot);
        chk("ack_cycle", cyc, v.exp_ack);
        req[c] = 1'b0;
      end
      if (mem_rd_en) begin
        ea = v.exp_first_mem + MAW'(issued);
        chk("mem_rd_addr", mem_rd_addr, ea);
        issued++;
        chk("outstanding_le2", (issued - beats) <= 2, 1);
      end
      if (prev_vld && !prev_rdy) begin
        chk("hold_vld", vld, onehot);
        chk("hold_data", data_bus[c*DW +: DW], prev_data);
      end
      if (vld != 0) begin
        chk("vld_onehot", vld, onehot);
        chk("beat_data", data_bus, bus_of(c, memf(v.exp_first_mem + MAW'(beats))));
      end
      if (v.rdy_mode == 0) r = 1'b1;
      else if (k < 4) r = (k == 0 || k == 3);
      else r = 1'($urandom_range(0, 1));
      k++;
      rdy = r ? onehot : '0;
      prev_vld = vld[c]; prev_rdy = r; prev_data = data_bus[c*DW +: DW];
      if (vld[c] && r) beats++;
      if (cmpl != 0) begin
        chk("cmpl_onehot", cmpl, onehot);
        cmpl_cyc = cyc;
      end
    end
    chk("cmpl_seen", cmpl_cyc >= 0, 1);
    chk("beat_count", beats, v.len);
    chk("read_count", issued, v.len);
    if (v.exp_cmpl >= 0) chk("cmpl_cycle", cmpl_cyc, v.exp_cmpl);
    req[c] = 1'b0;
    rdy = '0;
    tick();
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int n_ack, n_cmpl, cur, beats, cyc;
    logic [NC-1:0] exp_oh;
    tbl[0] = '{0, 32'h0000_0010, 4, 0, 1, 7, 20'h00010};
    tbl[1] = '{1, 32'h000F_FFFE, 4, 0, 1, 7, 20'hFFFFE};
    tbl[2] = '{2, 32'h0000_0040, 0, 0, 1, 2, 20'h00040};
    tbl[3] = '{3, 32'h0000_0080, 8, 1, 1, -1, 20'h00080};
    tbl[4] = '{1, 32'hABC1_2345, 1, 0, 1, 4, 20'h12345};
    tbl[5] = '{0, 32'h0000_0300, 3, 1, 1, -1, 20'h00300};

    rst = 1'b1; req = '0; req_id = '0; addr_bus = '0; len_bus = '0; rdy = '0;
    mem_rd_data = '0;
    #1;
    chk_quiet("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // All four request together: round-robin from pointer 0, each finishes before next ack.
    for (int i = 0; i < NC; i++) set_req(i, 32'h100 * (i + 1), 1);
    rdy = '1;
    n_ack = 0; n_cmpl = 0; cur = 0; cyc = 0;
    while (n_cmpl < NC && cyc < 100) begin
      tick();
      cyc++;
      if (ack != 0) begin
        exp_oh = NC'(1) << n_ack;
        chk("rr_order", ack, exp_oh);
        chk("cmpl_before_ack", n_cmpl, n_ack);
        for (int i = 0; i < NC; i++) if (ack[i]) begin cur = i; req[i] = 1'b0; end
        n_ack++;
      end
      if (vld != 0) chk("rr_beat", data_bus, bus_of(cur, memf(MAW'(32'h100 * (cur + 1)))));
      if (cmpl != 0) begin
        chk("rr_cmpl", cmpl, NC'(1) << cur);
        n_cmpl++;
      end
    end
    chk("rr_all_done", n_cmpl, NC);
    req = '0; rdy = '0;
    tick();

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Abort mid-stream after 3 of 10 beats; rr pointer must restart at 0.
    set_req(1, 32'h200, 10);
    rdy = 4'b0010;
    beats = 0; cyc = 0;
    while (beats < 3 && cyc < 50) begin
      tick();
      cyc++;
      if (ack[1]) req[1] = 1'b0;
      if (vld[1]) beats++;
    end
    chk("abort_reached", beats, 3);
    tick();
    chk("abort_mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_quiet("abort");
    rdy = '0;
    tick();
    chk("abort_no_cmpl", cmpl, 0);
    rst = 1'b0;
    set_req(0, 32'h400, 1);
    set_req(3, 32'h500, 1);
    rdy = '1;
    n_ack = 0; n_cmpl = 0; cyc = 0; cur = 0;
    while (n_cmpl < 2 && cyc < 60) begin
      tick();
      cyc++;
      if (ack != 0) begin
        chk("post_reset_grant", ack, (n_ack == 0) ? 4'b0001 : 4'b1000);
        for (int i = 0; i < NC; i++) if (ack[i]) begin cur = i; req[i] = 1'b0; end
        n_ack++;
      end
      if (vld != 0)
        chk("post_reset_beat", data_bus, bus_of(cur, memf((cur == 0) ? 20'h400 : 20'h500)));
      if (cmpl != 0) n_cmpl++;
    end
    chk("post_reset_done", n_cmpl, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
